// File: rtl/secded_mem_if.sv
// Byte-wide data memory bus between the SECDED engine (master) and memory (slave).
// Read data is valid the cycle after mem_rd_en; writes commit on the mem_wr_en edge.
interface secded_mem_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [7:0]        mem_rdata;
  logic              mem_wr_en;
  logic [7:0]        mem_wdata;

  modport master (
    output mem_addr,
    output mem_rd_en,
    input  mem_rdata,
    output mem_wr_en,
    output mem_wdata
  );

  modport slave (
    input  mem_addr,
    input  mem_rd_en,
    output mem_rdata,
    input  mem_wr_en,
    input  mem_wdata
  );
endinterface

// File: rtl/secded_mem_engine.sv
// Hamming(16,11) SECDED engine: walks NUM_MSG little-endian records in memory,
// encoding (mode 0) or decoding/correcting (mode 1) each one into the destination region.
module secded_mem_engine #(
  parameter int NUM_MSG  = 15,
  parameter int ADDR_W   = 8,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  output logic                done,
  secded_mem_if.master        mem,
  output logic [6:0]          err1_cnt,
  output logic [6:0]          err2_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_LO = 3'd1,
    S_RD_HI = 3'd2,
    S_CAP   = 3'd3,
    S_CALC  = 3'd4,
    S_WR_LO = 3'd5,
    S_WR_HI = 3'd6,
    S_FIN   = 3'd7
  } state_t;

  localparam logic [ADDR_W-1:0] SRC_A  = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] DST_A  = ADDR_W'(DST_BASE);
  localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1'b1);
  localparam logic [6:0]        LAST_I = 7'(NUM_MSG - 1);

  // Codeword layout {d11..d5, p8, d4..d2, p4, d1, p2, p1, p0}; bit k is Hamming position k.
  function automatic logic [15:0] secded_encode(input logic [11:1] d);
    logic p8, p4, p2, p1, p0;
    p8 = ^d[11:5];
    p4 = (^d[11:8]) ^ (^d[4:2]);
    p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
    p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
    p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
    return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
  endfunction

  // Returns {hi, lo} with hi = {status, 3'b000, d11..d9}; a double error passes data through.
  function automatic logic [15:0] secded_decode(input logic [15:0] cw);
    logic [3:0]  syn;
    logic        par;
    logic [15:0] fix;
    logic [1:0]  status;
    syn = 4'd0;
    for (int k = 1; k < 16; k++) begin
      if (cw[k]) begin
        syn = syn ^ 4'(k);
      end else begin
        syn = syn;
      end
    end
    par = ^cw;
    fix = cw;
    if (par) begin
      fix[syn] = ~cw[syn];
      status   = 2'b01;
    end else if (syn != 4'd0) begin
      status   = 2'b10;
    end else begin
      status   = 2'b00;
    end
    return {status, 3'b000, fix[15:13], fix[12:9], fix[7:5], fix[3]};
  endfunction

  function automatic logic [6:0] sat_inc(input logic [6:0] c);
    return (c == 7'd127) ? c : c + 7'd1;
  endfunction

  state_t            state_r, state_s;
  logic [6:0]        idx_r, idx_s;
  logic              mode_r, mode_s;
  logic              done_r, done_s;
  logic [7:0]        lo_r, lo_s;
  logic [7:0]        hi_r, hi_s;
  logic [7:0]        res_hi_r, res_hi_s;
  logic [6:0]        err1_r, err1_s;
  logic [6:0]        err2_r, err2_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic              rd_en_r, rd_en_s;
  logic              wr_en_r, wr_en_s;
  logic [7:0]        wdata_r, wdata_s;
  logic [15:0]       code_s;
  logic [ADDR_W-1:0] off_s;

  // Result of the current record in the latched direction.
  always_comb begin
    code_s = 16'h0000;
    if (mode_r) begin
      code_s = secded_decode({hi_r, lo_r});
    end else begin
      code_s = secded_encode({hi_r[2:0], lo_r});
    end
  end

  // Next-state logic plus next values for every registered output.
  always_comb begin
    state_s  = state_r;
    idx_s    = idx_r;
    mode_s   = mode_r;
    done_s   = done_r;
    lo_s     = lo_r;
    hi_s     = hi_r;
    res_hi_s = res_hi_r;
    err1_s   = err1_r;
    err2_s   = err2_r;
    addr_s   = addr_r;
    rd_en_s  = 1'b0;
    wr_en_s  = 1'b0;
    wdata_s  = wdata_r;

    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_RD_LO;
          idx_s   = 7'd0;
          mode_s  = mode;
          done_s  = 1'b0;
          err1_s  = 7'd0;
          err2_s  = 7'd0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RD_LO: state_s = S_RD_HI;
      S_RD_HI: begin
        lo_s    = mem.mem_rdata;
        state_s = S_CAP;
      end
      S_CAP: begin
        hi_s    = mem.mem_rdata;
        state_s = S_CALC;
      end
      S_CALC: begin
        res_hi_s = code_s[15:8];
        state_s  = S_WR_LO;
        if (mode_r && (code_s[15:14] == 2'b01)) begin
          err1_s = sat_inc(err1_r);
        end else if (mode_r && (code_s[15:14] == 2'b10)) begin
          err2_s = sat_inc(err2_r);
        end else begin
          err1_s = err1_r;
        end
      end
      S_WR_LO: state_s = S_WR_HI;
      S_WR_HI: begin
        if (idx_r == LAST_I) begin
          state_s = S_FIN;
        end else begin
          state_s = S_RD_LO;
          idx_s   = idx_r + 7'd1;
        end
      end
      S_FIN: begin
        state_s = S_IDLE;
        done_s  = 1'b1;
      end
      default: state_s = S_IDLE;
    endcase

    // Strobes and address are decoded from the state being entered so they are registered.
    off_s = ADDR_W'({idx_s, 1'b0});
    case (state_s)
      S_RD_LO: begin
        rd_en_s = 1'b1;
        addr_s  = SRC_A + off_s;
      end
      S_RD_HI: begin
        rd_en_s = 1'b1;
        addr_s  = SRC_A + off_s + ONE_A;
      end
      S_WR_LO: begin
        wr_en_s = 1'b1;
        addr_s  = DST_A + off_s;
        wdata_s = code_s[7:0];
      end
      S_WR_HI: begin
        wr_en_s = 1'b1;
        addr_s  = DST_A + off_s + ONE_A;
        wdata_s = res_hi_r;
      end
      default: begin
        rd_en_s = 1'b0;
        wr_en_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any run in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= S_IDLE;
      idx_r    <= 7'd0;
      mode_r   <= 1'b0;
      done_r   <= 1'b0;
      lo_r     <= 8'h00;
      hi_r     <= 8'h00;
      res_hi_r <= 8'h00;
      err1_r   <= 7'd0;
      err2_r   <= 7'd0;
      addr_r   <= '0;
      rd_en_r  <= 1'b0;
      wr_en_r  <= 1'b0;
      wdata_r  <= 8'h00;
    end else begin
      state_r  <= state_s;
      idx_r    <= idx_s;
      mode_r   <= mode_s;
      done_r   <= done_s;
      lo_r     <= lo_s;
      hi_r     <= hi_s;
      res_hi_r <= res_hi_s;
      err1_r   <= err1_s;
      err2_r   <= err2_s;
      addr_r   <= addr_s;
      rd_en_r  <= rd_en_s;
      wr_en_r  <= wr_en_s;
      wdata_r  <= wdata_s;
    end
  end

  assign done          = done_r;
  assign err1_cnt      = err1_r;
  assign err2_cnt      = err2_r;
  assign mem.mem_addr  = addr_r;
  assign mem.mem_rd_en = rd_en_r;
  assign mem.mem_wr_en = wr_en_r;
  assign mem.mem_wdata = wdata_r;

endmodule

// File: tb/tb_secded_mem_engine.sv
// Bench for secded_mem_engine: a 15-message instance and a 1-message instance whose
// records straddle the address wrap, each with its own behavioural byte memory.
module tb_secded_mem_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, mode_a, start_b, mode_b;
  logic       done_a, done_b;
  logic [6:0] e1_a, e2_a, e1_b, e2_b;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  secded_mem_if #(.ADDR_W(8)) mif_a ();
  secded_mem_if #(.ADDR_W(8)) mif_b ();

  secded_mem_engine #(.NUM_MSG(15), .ADDR_W(8), .SRC_BASE(0), .DST_BASE(30)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode_a), .done(done_a),
    .mem(mif_a), .err1_cnt(e1_a), .err2_cnt(e2_a));

  secded_mem_engine #(.NUM_MSG(1), .ADDR_W(8), .SRC_BASE(255), .DST_BASE(254)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode_b), .done(done_b),
    .mem(mif_b), .err1_cnt(e1_b), .err2_cnt(e2_b));

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] img_a [256];
  logic [7:0] img_b [256];
  logic       load_a = 1'b0;
  logic       load_b = 1'b0;
  int         wr_cnt_a = 0;
  logic       overlap = 1'b0;

  // Memory models: whole-image preload, synchronous read, write on strobe.
  always @(posedge clk) begin
    if (load_a) mem_a <= img_a;
    else if (mif_a.mem_wr_en) begin
      mem_a[mif_a.mem_addr] <= mif_a.mem_wdata;
      wr_cnt_a <= wr_cnt_a + 1;
    end
    if (mif_a.mem_rd_en) mif_a.mem_rdata <= mem_a[mif_a.mem_addr];
    if (load_b) mem_b <= img_b;
    else if (mif_b.mem_wr_en) mem_b[mif_b.mem_addr] <= mif_b.mem_wdata;
    if (mif_b.mem_rd_en) mif_b.mem_rdata <= mem_b[mif_b.mem_addr];
    if ((mif_a.mem_rd_en && mif_a.mem_wr_en) || (mif_b.mem_rd_en && mif_b.mem_wr_en)) overlap <= 1'b1;
  end

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: data bits fill the non-power-of-two positions in order; parity bit 2^j
  // covers every position with bit j set; bit 0 makes the whole word even.
  function automatic logic [15:0] ref_encode(input logic [10:0] d);
    logic [15:0] cw;
    int n;
    logic p;
    cw = 16'h0000;
    n = 0;
    for (int k = 1; k < 16; k++) if ((k & (k - 1)) != 0) begin cw[k] = d[n]; n++; end
    for (int j = 0; j < 4; j++) begin
      p = 1'b0;
      for (int k = 1; k < 16; k++) if ((((k >> j) & 1) == 1) && ((k & (k - 1)) != 0)) p = p ^ cw[k];
      cw[1 << j] = p;
    end
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  function automatic logic [10:0] ref_extract(input logic [15:0] cw);
    logic [10:0] d;
    int n;
    d = 11'h000;
    n = 0;
    for (int k = 1; k < 16; k++) if ((k & (k - 1)) != 0) begin d[n] = cw[k]; n++; end
    return d;
  endfunction

  // Nearest-codeword decode: valid word, or one flip away from a valid word, else double.
  task automatic ref_decode(input logic [15:0] cw, output logic [7:0] lo, output logic [7:0] hi,
                            output logic [1:0] st);
    logic [10:0] d;
    logic [15:0] t;
    d = ref_extract(cw);
    st = 2'b10;
    if (ref_encode(d) == cw) st = 2'b00;
    else begin
      for (int j = 0; j < 16; j++) begin
        t = cw;
        t[j] = ~t[j];
        if (st == 2'b10 && ref_encode(ref_extract(t)) == t) begin st = 2'b01; d = ref_extract(t); end
      end
    end
    lo = d[7:0];
    hi = {st, 3'b000, d[10:8]};
  endtask

  task automatic load(input bit sel);
    @(negedge clk);
    if (sel) load_b = 1'b1; else load_a = 1'b1;
    @(negedge clk);
    load_a = 1'b0;
    load_b = 1'b0;
  endtask

  // Start a run, optionally re-pulse start (inverted mode) at cycle poke; lat = cycles to done.
  task automatic run(input bit sel, input logic m, input int poke, output int lat);
    @(negedge clk);
    if (sel) begin start_b = 1'b1; mode_b = m; end else begin start_a = 1'b1; mode_a = m; end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    lat = 0;
    check("done_clear", sel ? done_b : done_a, 0);
    check("e1_clear", sel ? e1_b : e1_a, 0);
    check("e2_clear", sel ? e2_b : e2_a, 0);
    while (!(sel ? done_b : done_a) && lat < 300) begin
      @(negedge clk);
      lat++;
      if (lat == poke) begin
        if (sel) begin start_b = 1'b1; mode_b = ~m; end else begin start_a = 1'b1; mode_a = ~m; end
      end else begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
    end
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  typedef struct {
    logic       m;
    logic [7:0] lo, hi, elo, ehi;
    int         e1, e2;
  } vec_t;

  vec_t        tv [9];
  logic [7:0]  exp_lo [15];
  logic [7:0]  exp_hi [15];
  int          exp_e1, exp_e2;

  // Builds a 15-record decode image with nerr flips per record (-1 = random 0..2).
  task automatic build_decode(input int nerr_fixed);
    logic [15:0] cw;
    logic [1:0]  st;
    int nerr, p1;
    exp_e1 = 0;
    exp_e2 = 0;
    for (int k = 0; k < 15; k++) begin
      cw = ref_encode(11'($urandom));
      nerr = (nerr_fixed >= 0) ? nerr_fixed : (k == 0) ? 1 : (k == 1) ? 2 : int'($urandom_range(0, 2));
      p1 = int'($urandom_range(0, 15));
      if (nerr >= 1) cw[p1] = ~cw[p1];
      if (nerr == 2) begin p1 = (p1 + int'($urandom_range(1, 15))) % 16; cw[p1] = ~cw[p1]; end
      img_a[2 * k] = cw[7:0];
      img_a[2 * k + 1] = cw[15:8];
      ref_decode(cw, exp_lo[k], exp_hi[k], st);
      if (st == 2'b01) exp_e1++;
      if (st == 2'b10) exp_e2++;
    end
    for (int k = 30; k < 60; k++) img_a[k] = 8'hEE;
  endtask

  task automatic check_dst_a(input string nm);
    for (int k = 0; k < 15; k++) begin
      check({nm, "_lo"}, mem_a[30 + 2 * k], exp_lo[k]);
      check({nm, "_hi"}, mem_a[31 + 2 * k], exp_hi[k]);
    end
  endtask

  initial begin
    int lat, snap, guard;
    logic [15:0] cw;
    rst = 1'b1;
    start_a = 1'b0; mode_a = 1'b0; start_b = 1'b0; mode_b = 1'b0;
    for (int k = 0; k < 256; k++) begin img_a[k] = 8'h00; img_b[k] = 8'h00; end
    repeat (3) @(negedge clk);
    check("rst_done", done_a, 0);
    check("rst_rd_en", mif_a.mem_rd_en, 0);
    check("rst_wr_en", mif_a.mem_wr_en, 0);
    check("rst_addr", mif_a.mem_addr, 0);
    check("rst_wdata", mif_a.mem_wdata, 0);
    check("rst_e1", e1_a, 0);
    check("rst_e2", e2_a, 0);
    rst = 1'b0;

    // Single-record vectors; source lo at 255, hi wraps to 0, destination at 254/255.
    tv[0] = '{1'b0, 8'h55, 8'h05, 8'h5A, 8'hAA, 0, 0};
    tv[1] = '{1'b0, 8'h55, 8'hFD, 8'h5A, 8'hAA, 0, 0};
    tv[2] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0};
    tv[3] = '{1'b0, 8'hFF, 8'h07, 8'hFF, 8'hFF, 0, 0};
    tv[4] = '{1'b1, 8'h5A, 8'hAA, 8'h55, 8'h05, 0, 0};
    tv[5] = '{1'b1, 8'h1A, 8'hAA, 8'h55, 8'h45, 1, 0};
    tv[6] = '{1'b1, 8'h5B, 8'hAA, 8'h55, 8'h45, 1, 0};
    tv[7] = '{1'b1, 8'h1A, 8'hA8, 8'h41, 8'h85, 0, 1};
    tv[8] = '{1'b1, 8'hFF, 8'hFF, 8'hFF, 8'h07, 0, 0};
    for (int i = 0; i < 9; i++) begin
      img_b[255] = tv[i].lo;
      img_b[0]   = tv[i].hi;
      img_b[254] = 8'hEE;
      load(1'b1);
      run(1'b1, tv[i].m, -1, lat);
      check($sformatf("vec%0d_latency", i), lat, 7);
      check($sformatf("vec%0d_lo", i), mem_b[254], tv[i].elo);
      check($sformatf("vec%0d_hi", i), mem_b[255], tv[i].ehi);
      check($sformatf("vec%0d_e1", i), e1_b, tv[i].e1);
      check($sformatf("vec%0d_e2", i), e2_b, tv[i].e2);
    end

    // Random encode run with an ignored start pulse in the middle.
    for (int k = 0; k < 30; k++) img_a[k] = 8'($urandom);
    for (int k = 30; k < 60; k++) img_a[k] = 8'hEE;
    for (int k = 0; k < 15; k++) begin
      cw = ref_encode({img_a[2 * k + 1][2:0], img_a[2 * k]});
      exp_lo[k] = cw[7:0];
      exp_hi[k] = cw[15:8];
    end
    load(1'b0);
    run(1'b0, 1'b0, 40, lat);
    check("enc_latency", lat, 91);
    check_dst_a("enc");
    check("enc_e1", e1_a, 0);
    check("enc_e2", e2_a, 0);
    repeat (3) @(negedge clk);
    check("done_held", done_a, 1);

    // Random decode runs; the second start also clears the first run's counters.
    for (int r = 0; r < 2; r++) begin
      build_decode(-1);
      load(1'b0);
      run(1'b0, 1'b1, -1, lat);
      check("dec_latency", lat, 91);
      check_dst_a("dec");
      check("dec_e1", e1_a, exp_e1);
      check("dec_e2", e2_a, exp_e2);
    end

    // Reset asserted during WR_LO of message 3.
    build_decode(1);
    load(1'b0);
    @(negedge clk);
    start_a = 1'b1;
    mode_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    guard = 0;
    while (!(mif_a.mem_wr_en && mif_a.mem_addr == 8'd36) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("rst_window_found", int'(guard < 200), 1);
    check("pre_rst_e1", e1_a, 4);
    rst = 1'b1;
    #1;
    snap = wr_cnt_a;
    check("mid_rst_wr_en", mif_a.mem_wr_en, 0);
    check("mid_rst_done", done_a, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_writes", wr_cnt_a, snap);
    check("post_rst_lo3", mem_a[36], 8'hEE);
    check("post_rst_done", done_a, 0);
    check("post_rst_e1", e1_a, 0);
    check("post_rst_e2", e2_a, 0);
    run(1'b0, 1'b1, -1, lat);
    check("rerun_latency", lat, 91);
    check_dst_a("rerun");
    check("rerun_e1", e1_a, 15);
    check("rerun_e2", e2_a, 0);

    check("rd_wr_overlap", overlap, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
